// File: rtl/regfile_pkg.sv
// Shared defaults, derived-width helpers and the pending-counter opcode type
// for the register file / scoreboard slice.
package regfile_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NREG_DEF     = 32;
  localparam int unsigned NRD_DEF      = 2;
  localparam int unsigned PEND_MAX_DEF = 3;

  // Register address width for a file of nreg entries.
  function automatic int unsigned aw_of(int unsigned nreg);
    return $clog2(nreg);
  endfunction

  // Counter width able to hold 0..pend_max.
  function automatic int unsigned cw_of(int unsigned pend_max);
    return $clog2(pend_max + 1);
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC,
    CNT_CLR
  } cnt_op_e;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of read, issue, writeback and debug signals between the ID/WB logic
// (master) and the register file / scoreboard (slave).
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned NRD  = NRD_DEF
);
  localparam int unsigned AW = aw_of(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                wb_valid;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;
  logic [NREG-1:0]     busy_vec;
  logic                sb_err;

  modport master (
    output rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush, dbg_addr,
    input  rd_data, rd_busy, iss_ready, dbg_data, busy_vec, sb_err
  );

  modport slave (
    input  rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush, dbg_addr,
    output rd_data, rd_busy, iss_ready, dbg_data, busy_vec, sb_err
  );

endinterface

// File: rtl/pend_counter.sv
// Saturating in-flight-write counter for one destination register.
// Flags an underflow (writeback with nothing pending) through err.
module pend_counter
  import regfile_pkg::*;
#(
  parameter  int unsigned PEND_MAX = PEND_MAX_DEF,
  localparam int unsigned CW       = cw_of(PEND_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          err
);

  cnt_op_e op;

  // Decode the requested update; clear wins, paired inc/dec cancel out.
  always_comb begin
    op  = CNT_HOLD;
    err = 1'b0;
    if (clr) begin
      op = CNT_CLR;
    end else if (inc && dec) begin
      op  = CNT_HOLD;
      err = (cnt == '0);
    end else if (inc) begin
      op = (cnt != CW'(PEND_MAX)) ? CNT_INC : CNT_HOLD;
    end else if (dec) begin
      if (cnt == '0) err = 1'b1;
      else           op  = CNT_DEC;
    end
  end

  // Apply the decoded update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      case (op)
        CNT_CLR: cnt <= '0;
        CNT_INC: cnt <= cnt + CW'(1);
        CNT_DEC: cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// GPR array with write-through bypass on every read port, plus a per-register
// pending-write scoreboard used by ID to stall on RAW and WAW hazards.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned NRD      = NRD_DEF,
  parameter int unsigned PEND_MAX = PEND_MAX_DEF
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned AW = aw_of(NREG);
  localparam int unsigned CW = cw_of(PEND_MAX);

  logic [XLEN-1:0] mem      [NREG];
  logic [CW-1:0]   cnt_raw  [1:NREG-1];
  logic [CW-1:0]   pend_cnt [NREG];
  logic [NREG-1:1] cnt_err;
  logic            wb_live;
  logic            iss_rdy;
  logic            iss_acc;
  logic            iss_err;

  assign wb_live = bus.wb_valid && (bus.wb_addr != '0);

  // Architectural array; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < NREG; r++) mem[r] <= '0;
    end else if (wb_live) begin
      mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Counter view indexed from 0 so x0 reads as never pending.
  always_comb begin
    pend_cnt[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) pend_cnt[r] = cnt_raw[r];
  end

  // Issue acceptance: a same-cycle writeback frees a slot on a full register.
  always_comb begin
    iss_rdy = (bus.iss_rd == '0)
           || (pend_cnt[bus.iss_rd] != CW'(PEND_MAX))
           || (wb_live && (bus.wb_addr == bus.iss_rd));
    iss_acc = bus.iss_valid && iss_rdy && (bus.iss_rd != '0);
    iss_err = bus.iss_valid && !iss_rdy;
    bus.iss_ready = iss_rdy;
  end

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    pend_counter #(
      .PEND_MAX(PEND_MAX)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clr  (bus.flush),
      .inc  (iss_acc && (bus.iss_rd == AW'(r))),
      .dec  (bus.wb_valid && (bus.wb_addr == AW'(r))),
      .cnt  (cnt_raw[r]),
      .err  (cnt_err[r])
    );
  end

  // Sticky protocol error: underflowing writeback or issue while not ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     bus.sb_err <= 1'b0;
    else if (iss_err || (|cnt_err)) bus.sb_err <= 1'b1;
  end

  // Registered-state view of which registers have writes in flight.
  always_comb begin
    bus.busy_vec = '0;
    for (int unsigned r = 0; r < NREG; r++) bus.busy_vec[r] = (pend_cnt[r] != '0);
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit;

    // Bypassed read; busy compares against the count left after this cycle's
    // writeback, which also keeps an underflowing writeback from reading busy.
    always_comb begin
      a   = bus.rd_addr[i*AW +: AW];
      hit = wb_live && (bus.wb_addr == a);
      bus.rd_data[i*XLEN +: XLEN] = '0;
      if (reset) bus.rd_data[i*XLEN +: XLEN] = hit ? bus.wb_data : mem[a];
      bus.rd_busy[i] = (a != '0) && (pend_cnt[a] > CW'(hit));
    end
  end

  // Raw debug read, deliberately unbypassed.
  always_comb begin
    bus.dbg_data = mem[bus.dbg_addr];
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: a vector table plus hand-written
// sequences, with expectations queued at drive time and compared at sample time.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned PM   = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_scoreboard #(
    .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .PEND_MAX(PM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef enum int {K_RD0, K_RD1, K_BUSY, K_RDY, K_BV, K_ERR, K_DBG} kind_t;

  typedef struct {
    kind_t       kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [4:0]  dbga;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_busy;
    logic        e_rdy;
    logic [31:0] e_bv;
    logic        e_err;
    logic [31:0] e_dbg;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[12];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] observe(kind_t k);
    case (k)
      K_RD0:   return bus.rd_data[31:0];
      K_RD1:   return bus.rd_data[63:32];
      K_BUSY:  return {30'b0, bus.rd_busy};
      K_RDY:   return {31'b0, bus.iss_ready};
      K_BV:    return bus.busy_vec;
      K_ERR:   return {31'b0, bus.sb_err};
      K_DBG:   return bus.dbg_data;
      default: return '0;
    endcase
  endfunction

  task automatic push_exp(kind_t k, logic [31:0] v, string nm);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic drain();
    while (sbq.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sbq.pop_front();
      act = observe(e.kind);
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic wv,
                       input logic [4:0] wa, input logic [31:0] wd, input logic fl,
                       input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] dbga);
    bus.iss_valid = iv;
    bus.iss_rd    = ird;
    bus.wb_valid  = wv;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.flush     = fl;
    bus.rd_addr   = {ra1, ra0};
    bus.dbg_addr  = dbga;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // iv ird wv wa wd fl ra0 ra1 dbg | rd0 rd1 busy rdy | bv err dbg(after edge)
    vt = '{
      '{1'b1, 5'd5, 1'b0, 5'd0, 32'h00, 1'b0, 5'd5, 5'd0, 5'd5, 32'h00, 32'h00, 2'b00, 1'b1, 32'h20, 1'b0, 32'h00},
      '{1'b0, 5'd0, 1'b0, 5'd0, 32'h00, 1'b0, 5'd5, 5'd5, 5'd5, 32'h00, 32'h00, 2'b11, 1'b1, 32'h20, 1'b0, 32'h00},
      '{1'b0, 5'd5, 1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 5'd5, 5'd5, 32'h00, 32'hAA, 2'b00, 1'b1, 32'h00, 1'b0, 32'hAA},
      '{1'b1, 5'd3, 1'b0, 5'd0, 32'h00, 1'b0, 5'd3, 5'd5, 5'd3, 32'h00, 32'hAA, 2'b00, 1'b1, 32'h08, 1'b0, 32'h00},
      '{1'b1, 5'd3, 1'b0, 5'd0, 32'h00, 1'b0, 5'd3, 5'd5, 5'd3, 32'h00, 32'hAA, 2'b01, 1'b1, 32'h08, 1'b0, 32'h00},
      '{1'b1, 5'd3, 1'b0, 5'd0, 32'h00, 1'b0, 5'd3, 5'd5, 5'd3, 32'h00, 32'hAA, 2'b01, 1'b1, 32'h08, 1'b0, 32'h00},
      '{1'b1, 5'd3, 1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd5, 5'd3, 32'h33, 32'hAA, 2'b01, 1'b1, 32'h08, 1'b0, 32'h33},
      '{1'b0, 5'd3, 1'b0, 5'd0, 32'h00, 1'b0, 5'd3, 5'd5, 5'd3, 32'h33, 32'hAA, 2'b01, 1'b0, 32'h08, 1'b0, 32'h33},
      '{1'b1, 5'd3, 1'b0, 5'd0, 32'h00, 1'b0, 5'd3, 5'd5, 5'd3, 32'h33, 32'hAA, 2'b01, 1'b0, 32'h08, 1'b1, 32'h33},
      '{1'b0, 5'd0, 1'b1, 5'd3, 32'h31, 1'b0, 5'd3, 5'd5, 5'd3, 32'h31, 32'hAA, 2'b01, 1'b1, 32'h08, 1'b1, 32'h31},
      '{1'b0, 5'd0, 1'b1, 5'd3, 32'h32, 1'b0, 5'd3, 5'd5, 5'd3, 32'h32, 32'hAA, 2'b01, 1'b1, 32'h08, 1'b1, 32'h32},
      '{1'b0, 5'd0, 1'b1, 5'd3, 32'h34, 1'b0, 5'd3, 5'd5, 5'd3, 32'h34, 32'hAA, 2'b00, 1'b1, 32'h00, 1'b1, 32'h34}
    };

    // Power-on reset with a live writeback that must not bypass.
    reset = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd5, 5'd5, 5'd5);
    #2;
    push_exp(K_RD0,  32'h0, "por rd_data0");
    push_exp(K_RD1,  32'h0, "por rd_data1");
    push_exp(K_BUSY, 32'h0, "por rd_busy");
    push_exp(K_RDY,  32'h1, "por iss_ready");
    push_exp(K_BV,   32'h0, "por busy_vec");
    push_exp(K_ERR,  32'h0, "por sb_err");
    push_exp(K_DBG,  32'h0, "por dbg_data");
    drain();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    tick();

    // Vector table: bypass, WAW saturation, over-issue error, drain by writeback.
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].iv, vt[i].ird, vt[i].wv, vt[i].wa, vt[i].wd, vt[i].fl,
            vt[i].ra0, vt[i].ra1, vt[i].dbga);
      push_exp(K_RD0,  vt[i].e_rd0,           $sformatf("v%0d rd_data0", i));
      push_exp(K_RD1,  vt[i].e_rd1,           $sformatf("v%0d rd_data1", i));
      push_exp(K_BUSY, {30'b0, vt[i].e_busy}, $sformatf("v%0d rd_busy", i));
      push_exp(K_RDY,  {31'b0, vt[i].e_rdy},  $sformatf("v%0d iss_ready", i));
      #3;
      drain();
      tick();
      push_exp(K_BV,   vt[i].e_bv,            $sformatf("v%0d busy_vec", i));
      push_exp(K_ERR,  {31'b0, vt[i].e_err},  $sformatf("v%0d sb_err", i));
      push_exp(K_DBG,  vt[i].e_dbg,           $sformatf("v%0d dbg_data", i));
      drain();
    end

    // Mid-run reset: array, counters and sticky error clear immediately.
    reset = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd5, 5'd3, 5'd0);
    #1;
    push_exp(K_RD0,  32'h0, "rst rd_data0");
    push_exp(K_RD1,  32'h0, "rst rd_data1");
    push_exp(K_RDY,  32'h1, "rst iss_ready");
    push_exp(K_BUSY, 32'h0, "rst rd_busy");
    push_exp(K_BV,   32'h0, "rst busy_vec");
    push_exp(K_ERR,  32'h0, "rst sb_err");
    drain();
    for (int a = 0; a < 32; a++) begin
      bus.dbg_addr = 5'(a);
      #0.1;
      push_exp(K_DBG, 32'h0, $sformatf("rst dbg x%0d", a));
      drain();
    end
    tick();
    idle();
    reset = 1'b1;
    tick();
    for (int a = 3; a <= 5; a += 2) begin
      bus.dbg_addr = 5'(a);
      #1;
      push_exp(K_DBG, 32'h0, $sformatf("post-rst dbg x%0d", a));
      drain();
    end
    push_exp(K_BV,  32'h0, "post-rst busy_vec");
    push_exp(K_ERR, 32'h0, "post-rst sb_err");
    drain();

    // x7: issue, then issue+writeback together leaves the count at 1.
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 5'd7);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 1'b0, 5'd7, 5'd0, 5'd7);
    push_exp(K_RD0,  32'h77, "x7 pair rd_data0");
    push_exp(K_BUSY, 32'h0,  "x7 pair rd_busy");
    push_exp(K_RDY,  32'h1,  "x7 pair iss_ready");
    #3;
    drain();
    tick();
    idle();
    bus.rd_addr  = {5'd0, 5'd7};
    bus.dbg_addr = 5'd7;
    push_exp(K_BUSY, 32'h1,  "x7 next rd_busy");
    push_exp(K_BV,   32'h80, "x7 next busy_vec");
    push_exp(K_DBG,  32'h77, "x7 next dbg_data");
    push_exp(K_ERR,  32'h0,  "x7 next sb_err");
    #3;
    drain();
    drive(1'b0, 5'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd7, 5'd0, 5'd7);
    push_exp(K_BUSY, 32'h0,  "x7 drain rd_busy");
    push_exp(K_RD0,  32'h78, "x7 drain rd_data0");
    #3;
    drain();
    tick();
    push_exp(K_BV,  32'h0, "x7 drained busy_vec");
    push_exp(K_ERR, 32'h0, "x7 drained sb_err");
    drain();

    // x0: writeback ignored, issue always accepted and never counted.
    drive(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 5'd0);
    push_exp(K_RD0,  32'h0, "x0 rd_data0");
    push_exp(K_RD1,  32'h0, "x0 rd_data1");
    push_exp(K_RDY,  32'h1, "x0 iss_ready");
    push_exp(K_BUSY, 32'h0, "x0 rd_busy");
    #3;
    drain();
    tick();
    idle();
    push_exp(K_BV,  32'h0, "x0 busy_vec");
    push_exp(K_ERR, 32'h0, "x0 sb_err");
    push_exp(K_DBG, 32'h0, "x0 dbg_data");
    #3;
    drain();

    // Flush with x2/x4 pending and a same-cycle writeback to x4.
    drive(1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4);
    tick();
    drive(1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd4);
    tick();
    push_exp(K_BV, 32'h14, "flush pre busy_vec");
    drain();
    drive(1'b0, 5'd0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd0, 5'd0, 5'd4);
    tick();
    idle();
    bus.dbg_addr = 5'd4;
    push_exp(K_BV,  32'h0, "flush busy_vec");
    push_exp(K_DBG, 32'h4, "flush dbg x4");
    push_exp(K_ERR, 32'h0, "flush sb_err");
    #3;
    drain();
    drive(1'b0, 5'd0, 1'b1, 5'd2, 32'h22, 1'b0, 5'd2, 5'd0, 5'd2);
    push_exp(K_RD0,  32'h22, "late wb rd_data0");
    push_exp(K_BUSY, 32'h0,  "late wb rd_busy");
    #3;
    drain();
    tick();
    push_exp(K_ERR, 32'h1,  "late wb sb_err");
    push_exp(K_DBG, 32'h22, "late wb dbg x2");
    push_exp(K_BV,  32'h0,  "late wb busy_vec");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
